reg_wb_arbiter: RTL and testbench
=================================

// Module: reg_wb_arbiter
// PURPOSE
//  Write-side front end for the 32x32 register file. Merges main-pipeline
//  writebacks with results from multi-cycle units (divider, load miss) into
//  the single write port (write_reg/target_reg/write_rd_data).
//  Multi-cycle results are buffered in a small FIFO.
//  pending_mask lets issue logic detect hazards on registers with
//  outstanding writes.
// PARAMETERS
//  XLEN          32  data width
//  FIFO_DEPTH    2   multi-cycle result buffer entries (power of 2, >=2)
//  STARVE_LIMIT  4   consecutive pipe grants before the FIFO is forced
// PORTS
//  clk            in   1     clock; reg file writes on its negedge
//  rst            in   1     asynchronous, active-high reset
//  pipe_valid     in   1     pipeline writeback request this cycle
//  pipe_rd        in   5     pipeline destination register
//  pipe_data      in   XLEN  pipeline result
//  pipe_stall     out  1     pipeline must hold its writeback (not consumed)
//  mc_valid       in   1     multi-cycle result offered
//  mc_ready       out  1     FIFO can accept (valid&ready = transfer)
//  mc_rd          in   5     multi-cycle destination register
//  mc_data        in   XLEN  multi-cycle result
//  write_reg      out  1     register-file write enable
//  target_reg     out  5     register-file write address
//  write_rd_data  out  XLEN  register-file write data
//  pending_mask   out  32    bit i=1: FIFO holds a write to x[i]
// BEHAVIOUR
//  - Reset (async, rst=1): FIFO emptied, starve_cnt=0.
//    write_reg=0, target_reg=0, write_rd_data=0, pending_mask=0.
//    mc_ready=0 and pipe_stall=0 while rst=1.
//    Reset mid-operation discards buffered results.
//  - Outputs write_reg/target_reg/write_rd_data are registered (posedge).
//    A grant in cycle N appears in cycle N+1. The reg file commits it on the
//    negedge of N+1. write_reg is a one-cycle pulse per grant.
//  - Arbitration each posedge, fifo_ne = FIFO not empty:
//    * fifo_ne && (!pipe_valid || starve_cnt==STARVE_LIMIT): grant FIFO head,
//      pop.
//    * else if pipe_valid: grant pipe.
//    * else: write_reg=0 next cycle.
//  - pipe_stall = pipe_valid && FIFO granted (combinational).
//    A stalled pipe request is retried and must be held stable.
//  - starve_cnt: +1 when pipe granted while fifo_ne (saturates at
//    STARVE_LIMIT). Cleared on FIFO grant or when the FIFO is empty.
//  - mc_ready = !full. Decided from the current count only; no same-cycle
//    pop-then-push credit.
//  - No bypass: a multi-cycle result is enqueued first. Earliest write_reg
//    is 2 cycles after the transfer.
//  - Any grant with rd==0 is consumed but yields write_reg=0 (x0 never
//    written).
//  - mc transfer with mc_rd==0 is accepted (handshake completes) and not
//    enqueued.
//  - FIFO is strict in-order; pointers wrap modulo FIFO_DEPTH.
//    Push and pop in the same cycle are allowed when not full.
//  - pending_mask = OR of one-hot(rd) over valid FIFO entries. Bit 0 is
//    always 0. Registered, so it updates the cycle after push/pop.
//  - The arbiter never reorders a pipe write against a FIFO write to the
//    same rd. Issue logic must stall on pending_mask.
// TESTING
//  1 Reset: rst=1 mid-traffic -> all outputs 0 immediately, mc_ready=0.
//    After release: mc_ready=1, pending_mask=0.
//  2 pipe_valid=1 rd=5 data=32'hDEAD_BEEF at cycle N -> cycle N+1:
//    write_reg=1, target_reg=5, write_rd_data=32'hDEAD_BEEF.
//    Reg file x5 reads DEAD_BEEF after the negedge.
//  3 mc push rd=7 data=0x11 with pipe idle -> pending_mask[7]=1 next cycle.
//    Write of x7 two cycles after transfer, then pending_mask[7]=0.
//  4 FIFO holds rd=9, pipe_valid continuously -> 4 pipe grants, then FIFO
//    granted with pipe_stall=1 for that cycle, then pipe resumes.
//  5 Two mc pushes with no drain (pipe saturating) -> mc_ready=0.
//    A third mc_valid is held, not lost. It is accepted after the first pop.
//  6 pipe rd=0 and mc rd=0 transfers -> handshakes complete, write_reg stays
//    0, pending_mask unchanged.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Write-side arbiter for the register file: merges pipeline writebacks with
// buffered multi-cycle results into one registered write port.
module reg_wb_arbiter #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pipe_valid,
   input  logic [4:0]      pipe_rd,
   input  logic [XLEN-1:0] pipe_data,
   output logic            pipe_stall,
   input  logic            mc_valid,
   output logic            mc_ready,
   input  logic [4:0]      mc_rd,
   input  logic [XLEN-1:0] mc_data,
   output logic            write_reg,
   output logic [4:0]      target_reg,
   output logic [XLEN-1:0] write_rd_data,
   output logic [31:0]     pending_mask
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic [FIFO_DEPTH-1:0] slot_vld;
   logic [FIFO_DEPTH-1:0] vld_n;
   logic [4:0]            slot_rd   [FIFO_DEPTH];
   logic [XLEN-1:0]       slot_data [FIFO_DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [SW-1:0]         starve_cnt;
   logic [SW-1:0]         starve_n;
   logic                  fifo_ne;
   logic                  fifo_full;
   logic                  fifo_grant;
   logic                  pipe_grant;
   logic                  push;
   logic                  grant_any;
   logic [4:0]            grant_rd;
   logic [XLEN-1:0]       grant_data;
   logic [31:0]           mask_n;

   // Occupancy is tracked per slot: in a ring, the write slot is busy only
   // when full and the read slot is free only when empty.
   always_comb begin
      fifo_ne    = slot_vld[rd_ptr];
      fifo_full  = slot_vld[wr_ptr];
      fifo_grant = fifo_ne && (!pipe_valid || (starve_cnt == SW'(STARVE_LIMIT)));
      pipe_grant = pipe_valid && !fifo_grant;
      grant_any  = fifo_grant || pipe_grant;
      grant_rd   = fifo_grant ? slot_rd[rd_ptr]   : pipe_rd;
      grant_data = fifo_grant ? slot_data[rd_ptr] : pipe_data;
      mc_ready   = !rst && !fifo_full;
      pipe_stall = !rst && pipe_valid && fifo_grant;
      push       = mc_valid && mc_ready && (mc_rd != 5'd0);
   end

   always_comb begin
      starve_n = starve_cnt;
      if (fifo_grant || !fifo_ne) begin
         starve_n = '0;
      end else if (pipe_grant && (starve_cnt != SW'(STARVE_LIMIT))) begin
         starve_n = starve_cnt + SW'(1);
      end
   end

   // Mask is built from post-update occupancy so the register reflects the
   // FIFO contents in the cycle after a push or pop.
   always_comb begin
      vld_n  = slot_vld;
      mask_n = '0;
      if (fifo_grant) vld_n[rd_ptr] = 1'b0;
      if (push)       vld_n[wr_ptr] = 1'b1;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         if (vld_n[i]) begin
            if (push && (PW'(i) == wr_ptr)) mask_n[mc_rd]      = 1'b1;
            else                            mask_n[slot_rd[i]] = 1'b1;
         end
      end
      mask_n[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         slot_rd[wr_ptr]   <= mc_rd;
         slot_data[wr_ptr] <= mc_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_vld      <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         starve_cnt    <= '0;
         write_reg     <= 1'b0;
         target_reg    <= '0;
         write_rd_data <= '0;
         pending_mask  <= '0;
      end else begin
         slot_vld     <= vld_n;
         starve_cnt   <= starve_n;
         pending_mask <= mask_n;
         if (fifo_grant) rd_ptr <= rd_ptr + PW'(1);
         if (push)       wr_ptr <= wr_ptr + PW'(1);
         write_reg <= grant_any && (grant_rd != 5'd0);
         if (grant_any) begin
            target_reg    <= grant_rd;
            write_rd_data <= grant_data;
         end
      end
   end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: queue-based reference model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_reg_wb_arbiter;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            pipe_valid;
   logic [4:0]      pipe_rd;
   logic [XLEN-1:0] pipe_data;
   logic            pipe_stall;
   logic            mc_valid;
   logic            mc_ready;
   logic [4:0]      mc_rd;
   logic [XLEN-1:0] mc_data;
   logic            write_reg;
   logic [4:0]      target_reg;
   logic [XLEN-1:0] write_rd_data;
   logic [31:0]     pending_mask;

   reg_wb_arbiter #(
      .XLEN(XLEN),
      .FIFO_DEPTH(DEPTH),
      .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pipe_valid(pipe_valid),
      .pipe_rd(pipe_rd),
      .pipe_data(pipe_data),
      .pipe_stall(pipe_stall),
      .mc_valid(mc_valid),
      .mc_ready(mc_ready),
      .mc_rd(mc_rd),
      .mc_data(mc_data),
      .write_reg(write_reg),
      .target_reg(target_reg),
      .write_rd_data(write_rd_data),
      .pending_mask(pending_mask)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of pending results and a count of
   // consecutive pipe wins over a non-empty queue.
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   wb_t         q[$];
   int          starve = 0;
   logic        m_wr   = 1'b0;
   logic [4:0]  m_rd   = '0;
   logic [31:0] m_data = '0;
   logic [31:0] m_mask = '0;

   always @(posedge clk or posedge rst) begin : model
      bit  ne, ready, take_fifo;
      wb_t head;
      if (rst) begin
         q.delete();
         starve = 0;
         m_wr   = 1'b0;
         m_rd   = '0;
         m_data = '0;
         m_mask = '0;
      end else begin
         ne        = (q.size() != 0);
         ready     = (q.size() < DEPTH);
         take_fifo = ne && (!pipe_valid || starve == LIMIT);
         if (take_fifo) begin
            head   = q.pop_front();
            m_wr   = (head.rd != 0);
            m_rd   = head.rd;
            m_data = head.data;
            starve = 0;
         end else if (pipe_valid) begin
            m_wr   = (pipe_rd != 0);
            m_rd   = pipe_rd;
            m_data = pipe_data;
            starve = ne ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
         end else begin
            m_wr   = 1'b0;
            starve = 0;
         end
         if (mc_valid && ready && mc_rd != 0) q.push_back({mc_rd, mc_data});
         m_mask = '0;
         foreach (q[i]) m_mask[q[i].rd] = 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("write_reg", write_reg, m_wr);
      if (m_wr) begin
         chk("target_reg", target_reg, m_rd);
         chk("write_rd_data", write_rd_data, m_data);
      end
      chk("pending_mask", pending_mask, m_mask);
      chk("mc_ready", mc_ready, !rst && (q.size() < DEPTH));
      chk("pipe_stall", pipe_stall, !rst && pipe_valid && (q.size() != 0) && (starve == LIMIT));
   end

   logic [31:0] rf [32];
   initial foreach (rf[i]) rf[i] = '0;
   always @(negedge clk) if (write_reg === 1'b1 && target_reg != 0) rf[target_reg] <= write_rd_data;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int waited;
      pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
      mc_valid = 0; mc_rd = 0; mc_data = 0;

      // power-on reset
      step(); step();
      @(negedge clk);
      chk("rst_write_reg", write_reg, 0);
      chk("rst_target_reg", target_reg, 0);
      chk("rst_wdata", write_rd_data, 0);
      chk("rst_mask", pending_mask, 0);
      chk("rst_mc_ready", mc_ready, 0);
      chk("rst_pipe_stall", pipe_stall, 0);
      step(); rst = 0;
      @(negedge clk);
      chk("rel_mc_ready", mc_ready, 1);
      chk("rel_mask", pending_mask, 0);

      // pipe writeback latency
      step(); pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hDEAD_BEEF;
      step(); pipe_valid = 0;
      @(negedge clk);
      chk("t2_write_reg", write_reg, 1);
      chk("t2_target", target_reg, 5);
      chk("t2_data", write_rd_data, 32'hDEAD_BEEF);
      step();
      chk("t2_rf_x5", rf[5], 32'hDEAD_BEEF);

      // mc result goes through the FIFO
      mc_valid = 1; mc_rd = 7; mc_data = 32'h11;
      step(); mc_valid = 0;
      @(negedge clk);
      chk("t3_mask_set", pending_mask, 32'h0000_0080);
      chk("t3_no_write_yet", write_reg, 0);
      step();
      @(negedge clk);
      chk("t3_write_reg", write_reg, 1);
      chk("t3_target", target_reg, 7);
      chk("t3_data", write_rd_data, 32'h11);
      chk("t3_mask_clr", pending_mask, 0);
      step(); step();

      // starvation limit forces the FIFO through a busy pipe
      pipe_valid = 1; pipe_rd = 1; pipe_data = 32'h101;
      mc_valid = 1; mc_rd = 9; mc_data = 32'h99;
      step(); mc_valid = 0;
      for (int c = 0; c < 8; c++) begin
         automatic int r = (c < 5) ? c + 2 : c + 1;
         pipe_rd   = 5'(r);
         pipe_data = 32'h100 + 32'(r);
         @(negedge clk);
         chk("t4_stall", pipe_stall, (c == 4) ? 1 : 0);
         if (c == 5) begin
            chk("t4_fifo_target", target_reg, 9);
            chk("t4_fifo_data", write_rd_data, 32'h99);
         end
         step();
      end
      pipe_valid = 0;
      step();

      // full FIFO holds off a third result until the first pop
      pipe_valid = 1; pipe_rd = 20; pipe_data = 32'h2000;
      mc_valid = 1; mc_rd = 10; mc_data = 32'hA;
      step(); mc_rd = 11; mc_data = 32'hB;
      step(); mc_rd = 12; mc_data = 32'hC;
      @(negedge clk);
      chk("t5_full_ready", mc_ready, 0);
      chk("t5_mask_two", pending_mask, 32'h0000_0C00);
      waited = 1;
      forever begin
         step();
         @(negedge clk);
         if (mc_ready) break;
         waited++;
         if (waited > 20) begin
            chk("t5_accept_timeout", 0, 1);
            break;
         end
      end
      chk("t5_held_cycles", waited, 4);
      step(); mc_valid = 0; pipe_valid = 0;
      @(negedge clk);
      chk("t5_mask_after", pending_mask, 32'h0000_1800);
      repeat (4) step();

      // x0 targets are consumed silently
      pipe_valid = 1; pipe_rd = 0; pipe_data = 32'hBAD;
      mc_valid = 1; mc_rd = 0; mc_data = 32'hBAD;
      @(negedge clk);
      chk("t6_mc_ready", mc_ready, 1);
      chk("t6_no_stall", pipe_stall, 0);
      step(); pipe_valid = 0; mc_valid = 0;
      @(negedge clk);
      chk("t6_write_reg", write_reg, 0);
      chk("t6_mask", pending_mask, 0);
      step(); step();

      // reset in the middle of traffic
      pipe_valid = 1; pipe_rd = 4; pipe_data = 32'h44;
      mc_valid = 1; mc_rd = 3; mc_data = 32'h33;
      step(); mc_valid = 0;
      chk("t1_pre_write", write_reg, 1);
      #2; rst = 1; #1;
      chk("t1_wr", write_reg, 0);
      chk("t1_target", target_reg, 0);
      chk("t1_data", write_rd_data, 0);
      chk("t1_mask", pending_mask, 0);
      chk("t1_mc_ready", mc_ready, 0);
      chk("t1_stall", pipe_stall, 0);
      pipe_valid = 0;
      step(); rst = 0;
      @(negedge clk);
      chk("t1_rel_ready", mc_ready, 1);
      chk("t1_rel_mask", pending_mask, 0);
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
